// File: rtl/instr_fetch_unit.sv
// Single-entry instruction fetch stage: issues one memory request, buffers the
// returned word for decode, and redirects on branch.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] next_PC,
  output logic [15:0] cur_PC,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] fetch_count
);

  typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_next;
  logic [15:0] pc_next, instr_next, count_next;
  logic        valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      cur_PC      <= RESET_PC;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      state       <= state_next;
      cur_PC      <= pc_next;
      instr       <= instr_next;
      instr_valid <= valid_next;
      fetch_count <= count_next;
    end
  end

  // Branch wins over both ack and accept: returned data or the buffered word is dropped.
  always_comb begin
    state_next = state;
    pc_next    = cur_PC;
    instr_next = instr;
    valid_next = instr_valid;
    count_next = fetch_count;
    if (branch_valid) begin
      state_next = FETCH;
      pc_next    = branch_target;
      valid_next = 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ack) begin
          state_next = FULL;
          pc_next    = next_PC;
          instr_next = imem_data;
          valid_next = 1'b1;
        end
        FULL: if (instr_ready) begin
          state_next = FETCH;
          valid_next = 1'b0;
          count_next = fetch_count + 16'd1;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = cur_PC;

endmodule
